// File: rtl/mem_stage_pkg.sv
// Shared widths, MIPS load/store opcodes and small decode helpers for the
// memory-access stage.
package mem_stage_pkg;

    localparam int DWIDTH = 32;
    localparam int AWIDTH = 5;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // What the write-back mux presents in the cycle after an edge.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,   // idle, store or alignment fault: data is zero
        WB_LOAD = 2'd1,   // lane extraction from the memory read register
        WB_PASS = 2'd2    // registered ALU value
    } wb_kind_e;

    // Halfword accesses need an even address, word accesses a multiple of 4.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: bad = lane[0];
            OP_LW, OP_SW:         bad = (lane != 2'b00);
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Byte lanes touched by an aligned store.
    function automatic logic [3:0] store_lanes(input logic [5:0] op, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (op)
            OP_SB:   be = 4'b0001 << lane;
            OP_SH:   be = lane[1] ? 4'b1100 : 4'b0011;
            OP_SW:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-to-memory stage bus. Validity: ms_i_ce qualifies every ms_i_*
// field; an instruction is taken on an edge where ms_i_ce=1, ms_i_stall=0 and
// ms_i_flush=0 (flush wins over stall). ms_o_ce qualifies every ms_o_* field
// for exactly the cycle after the taking edge, and is held while stalled.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              ms_i_ce;
    logic [DWIDTH-1:0] ms_i_alu_value;
    logic [5:0]        ms_i_opcode;
    logic [DWIDTH-1:0] ms_i_rs2_data;
    logic              ms_i_reg_wr;
    logic [AWIDTH-1:0] ms_i_rd_addr;
    logic              ms_i_stall;
    logic              ms_i_flush;

    logic              ms_o_ce;
    logic [DWIDTH-1:0] ms_o_wb_data;
    logic [AWIDTH-1:0] ms_o_rd_addr;
    logic              ms_o_reg_wr;
    logic              ms_o_misaligned;

    // Execute side: drives the instruction, observes the result.
    modport master (
        output ms_i_ce, ms_i_alu_value, ms_i_opcode, ms_i_rs2_data,
               ms_i_reg_wr, ms_i_rd_addr, ms_i_stall, ms_i_flush,
        input  ms_o_ce, ms_o_wb_data, ms_o_rd_addr, ms_o_reg_wr, ms_o_misaligned
    );

    // Memory stage side.
    modport slave (
        input  ms_i_ce, ms_i_alu_value, ms_i_opcode, ms_i_rs2_data,
               ms_i_reg_wr, ms_i_rd_addr, ms_i_stall, ms_i_flush,
        output ms_o_ce, ms_o_wb_data, ms_o_rd_addr, ms_o_reg_wr, ms_o_misaligned
    );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Single-port synchronous data RAM: byte write enables, registered read data
// that holds while the read enable is low. Contents are never reset.
module data_mem
    import mem_stage_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ren,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DWIDTH-1:0]     wdata,
    output logic [DWIDTH-1:0]     rdata
);

    logic [DWIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Byte-lane writes; no reset so contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Read register: captures the addressed word when enabled, else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: accept/align/byte-enable decode, one pipeline
// register stage, and load lane extraction from the synchronous RAM output.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic       ms_clk,
    input  logic       ms_rst,
    mem_stage_if.slave bus
);

    logic              accept;
    logic              advance;
    logic              is_load;
    logic              is_store;
    logic              misaligned;
    logic [1:0]        lane_in;
    logic [3:0]        byte_en;
    logic [DWIDTH-1:0] store_data;
    logic [DWIDTH-1:0] mem_rdata;

    logic              ce_q;
    logic              reg_wr_q;
    logic              mis_q;
    logic [AWIDTH-1:0] rd_q;
    logic [5:0]        op_q;
    logic [1:0]        lane_q;
    logic [DWIDTH-1:0] alu_q;
    wb_kind_e          kind_q;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DWIDTH-1:0] wb_data;

    // Decode the presented instruction: acceptance, alignment, byte lanes.
    always_comb begin
        lane_in    = bus.ms_i_alu_value[1:0];
        is_load    = bus.ms_i_opcode inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        is_store   = bus.ms_i_opcode inside {OP_SB, OP_SH, OP_SW};
        misaligned = is_misaligned(bus.ms_i_opcode, lane_in);
        accept     = bus.ms_i_ce & ~bus.ms_i_stall & ~bus.ms_i_flush;
        // Flush must still clear the outputs even while stalled.
        advance    = ~bus.ms_i_stall | bus.ms_i_flush;
        byte_en    = (accept && is_store && !misaligned)
                   ? store_lanes(bus.ms_i_opcode, lane_in) : 4'b0000;
        case (bus.ms_i_opcode)
            OP_SB:   store_data = {4{bus.ms_i_rs2_data[7:0]}};
            OP_SH:   store_data = {2{bus.ms_i_rs2_data[15:0]}};
            default: store_data = bus.ms_i_rs2_data;
        endcase
    end

    data_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_data_mem (
        .clk   (ms_clk),
        .rst_n (ms_rst),
        .ren   (advance),
        .we    (byte_en),
        .addr  (bus.ms_i_alu_value[DEPTH_LOG2+1:2]),
        .wdata (store_data),
        .rdata (mem_rdata)
    );

    // Pipeline registers: advance unless stalled; not-accepted slots drop valid.
    always_ff @(posedge ms_clk or negedge ms_rst) begin
        if (!ms_rst) begin
            ce_q     <= 1'b0;
            reg_wr_q <= 1'b0;
            mis_q    <= 1'b0;
            rd_q     <= '0;
            op_q     <= '0;
            lane_q   <= '0;
            alu_q    <= '0;
            kind_q   <= WB_NONE;
        end else if (advance) begin
            ce_q     <= accept;
            mis_q    <= accept & misaligned;
            reg_wr_q <= accept & ~misaligned & ~is_store & bus.ms_i_reg_wr;
            rd_q     <= bus.ms_i_rd_addr;
            op_q     <= bus.ms_i_opcode;
            lane_q   <= lane_in;
            alu_q    <= bus.ms_i_alu_value;
            if (!accept || misaligned || is_store) begin
                kind_q <= WB_NONE;
            end else if (is_load) begin
                kind_q <= WB_LOAD;
            end else begin
                kind_q <= WB_PASS;
            end
        end
    end

    // Write-back mux: lane extraction with sign/zero extension for loads.
    always_comb begin
        byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        wb_data  = '0;
        case (kind_q)
            WB_LOAD: begin
                case (op_q)
                    OP_LB:   wb_data = {{24{byte_sel[7]}}, byte_sel};
                    OP_LBU:  wb_data = {24'h0, byte_sel};
                    OP_LH:   wb_data = {{16{half_sel[15]}}, half_sel};
                    OP_LHU:  wb_data = {16'h0, half_sel};
                    default: wb_data = mem_rdata;
                endcase
            end
            WB_PASS: wb_data = alu_q;
            default: wb_data = '0;
        endcase
    end

    assign bus.ms_o_ce         = ce_q;
    assign bus.ms_o_reg_wr     = reg_wr_q;
    assign bus.ms_o_misaligned = mis_q;
    assign bus.ms_o_rd_addr    = rd_q;
    assign bus.ms_o_wb_data    = wb_data;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic, checked
// against a byte-array memory model with per-cycle expected outputs.
module tb_mem_stage;

    localparam int DEPTH_LOG2 = 10;
    localparam int NBYTES     = 4 << DEPTH_LOG2;
    localparam int PREFILL_W  = 64;

    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
    localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

    typedef struct packed {
        logic        ce;
        logic        wr;
        logic        mis;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic ms_clk = 1'b0;
    logic ms_rst = 1'b0;

    mem_stage_if bus ();

    mem_stage #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .ms_clk (ms_clk),
        .ms_rst (ms_rst),
        .bus    (bus.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 ms_clk = ~ms_clk;

    // ---------------- scoreboard state ----------------
    logic [7:0]  mbytes [NBYTES];
    exp_t        cur;
    logic [39:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int access_size(input logic [5:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    // Reference behaviour for one clock edge, from the current bus inputs.
    task automatic model_step();
        exp_t        nx;
        logic [5:0]  op;
        int          b, sz;
        logic        st, ld, sgn;
        logic [31:0] v, mask;
        nx = cur;
        if (!ms_rst) begin
            nx = '0;
        end else if (bus.ms_i_flush) begin
            nx.ce = 0; nx.wr = 0; nx.mis = 0;
        end else if (bus.ms_i_stall) begin
            nx = cur;
        end else if (!bus.ms_i_ce) begin
            nx.ce = 0; nx.wr = 0; nx.mis = 0;
        end else begin
            op  = bus.ms_i_opcode;
            b   = int'(bus.ms_i_alu_value[DEPTH_LOG2+1:0]);
            sz  = access_size(op);
            st  = (op == SB) || (op == SH) || (op == SW);
            ld  = (sz != 0) && !st;
            sgn = (op == LB) || (op == LH);
            nx.ce   = 1;
            nx.rd   = bus.ms_i_rd_addr;
            nx.mis  = (sz != 0) && (b % sz != 0);
            nx.wr   = 0;
            nx.data = 0;
            if (!nx.mis) begin
                if (st) begin
                    for (int k = 0; k < sz; k++) mbytes[b + k] = bus.ms_i_rs2_data[8*k +: 8];
                end else if (ld) begin
                    v = 0;
                    for (int k = 0; k < sz; k++) v[8*k +: 8] = mbytes[b + k];
                    mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
                    if (sgn && v[8*sz-1]) v = v | ~mask;
                    nx.data = v;
                    nx.wr   = bus.ms_i_reg_wr;
                end else begin
                    nx.data = bus.ms_i_alu_value;
                    nx.wr   = bus.ms_i_reg_wr;
                end
            end
        end
        cur = nx;
        exp_q.push_back(40'(cur));
    endtask

    task automatic check_outputs();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("exp_q_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_t'(exp_q.pop_front());
        chk("ce",         {31'b0, bus.ms_o_ce},         {31'b0, e.ce});
        chk("reg_wr",     {31'b0, bus.ms_o_reg_wr},     {31'b0, e.wr});
        chk("misaligned", {31'b0, bus.ms_o_misaligned}, {31'b0, e.mis});
        if (e.ce) chk("rd_addr", {27'b0, bus.ms_o_rd_addr}, {27'b0, e.rd});
        if (e.ce && !e.mis) chk("wb_data", bus.ms_o_wb_data, e.data);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ce"},     {31'b0, bus.ms_o_ce},         32'd0);
        chk({tag, "_reg_wr"}, {31'b0, bus.ms_o_reg_wr},     32'd0);
        chk({tag, "_mis"},    {31'b0, bus.ms_o_misaligned}, 32'd0);
        chk({tag, "_rd"},     {27'b0, bus.ms_o_rd_addr},    32'd0);
        chk({tag, "_wb"},     bus.ms_o_wb_data,             32'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic wr, input logic ce,
                         input logic st, input logic fl);
        bus.ms_i_opcode    = op;
        bus.ms_i_alu_value = a;
        bus.ms_i_rs2_data  = d;
        bus.ms_i_rd_addr   = rd;
        bus.ms_i_reg_wr    = wr;
        bus.ms_i_ce        = ce;
        bus.ms_i_stall     = st;
        bus.ms_i_flush     = fl;
    endtask

    // One edge: model reacts at the rising edge, outputs checked on the falling one.
    task automatic cycle();
        @(posedge ms_clk);
        model_step();
        @(negedge ms_clk);
        check_outputs();
    endtask

    task automatic op_do(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd);
        drive(op, a, d, rd, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
    endtask

    task automatic idle();
        drive(6'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
    endtask

    logic [5:0] op_tbl [10];

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int          idx;
        op_tbl = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'h00, 6'h0F};
        cur = '0;
        drive(6'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge ms_clk);
        check_all_zero("reset");
        ms_rst = 1'b1;

        for (int i = 0; i < PREFILL_W; i++) op_do(SW, i * 4, $urandom, 5'd0);

        // word store / load
        op_do(SW, 32'h10, 32'hDEADBEEF, 5'd0);
        op_do(LW, 32'h10, 32'h0, 5'd9);
        chk("lw_data", bus.ms_o_wb_data, 32'hDEADBEEF);
        chk("lw_rd", {27'b0, bus.ms_o_rd_addr}, 32'd9);
        chk("lw_wr", {31'b0, bus.ms_o_reg_wr}, 32'd1);

        // sub-word loads
        op_do(SW, 32'h10, 32'h80FF1234, 5'd0);
        op_do(LB, 32'h13, 32'h0, 5'd1);  chk("lb_13",  bus.ms_o_wb_data, 32'hFFFFFF80);
        op_do(LBU, 32'h13, 32'h0, 5'd1); chk("lbu_13", bus.ms_o_wb_data, 32'h00000080);
        op_do(LH, 32'h12, 32'h0, 5'd1);  chk("lh_12",  bus.ms_o_wb_data, 32'hFFFF80FF);
        op_do(LHU, 32'h12, 32'h0, 5'd1); chk("lhu_12", bus.ms_o_wb_data, 32'h000080FF);
        op_do(SB, 32'h11, 32'h55, 5'd0);
        op_do(LW, 32'h10, 32'h0, 5'd2);  chk("sb_lw",  bus.ms_o_wb_data, 32'h80FF5534);

        // misalignment
        op_do(LW, 32'h11, 32'h0, 5'd5);
        chk("mis_flag", {31'b0, bus.ms_o_misaligned}, 32'd1);
        chk("mis_wr",   {31'b0, bus.ms_o_reg_wr},     32'd0);
        chk("mis_ce",   {31'b0, bus.ms_o_ce},         32'd1);
        op_do(SW, 32'h12, 32'hFFFFFFFF, 5'd0);
        op_do(LW, 32'h10, 32'h0, 5'd2);  chk("mis_sw_nowrite", bus.ms_o_wb_data, 32'h80FF5534);

        // stall holds a pending store until release
        op_do(SW, 32'h20, 32'h0, 5'd0);
        op_do(SW, 32'h28, 32'h0, 5'd0);
        drive(SW, 32'h20, 32'h11223344, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) cycle();
        drive(SW, 32'h20, 32'h11223344, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        op_do(LW, 32'h20, 32'h0, 5'd4);  chk("stall_sw", bus.ms_o_wb_data, 32'h11223344);
        // a stalled store that is then flushed never lands
        drive(SW, 32'h28, 32'h99999999, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle();
        drive(SW, 32'h28, 32'h99999999, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle();
        op_do(LW, 32'h28, 32'h0, 5'd4);  chk("stall_flush_sw", bus.ms_o_wb_data, 32'h0);

        // flush
        op_do(SW, 32'h24, 32'h12345678, 5'd0);
        drive(SW, 32'h24, 32'hAAAA5555, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle();
        chk("flush_ce", {31'b0, bus.ms_o_ce}, 32'd0);
        op_do(LW, 32'h24, 32'h0, 5'd6);  chk("flush_nowrite", bus.ms_o_wb_data, 32'h12345678);

        // pass-through and address aliasing
        op_do(6'h00, 32'd42, 32'h0, 5'd8);
        chk("pass_data", bus.ms_o_wb_data, 32'd42);
        chk("pass_rd",   {27'b0, bus.ms_o_rd_addr}, 32'd8);
        chk("pass_wr",   {31'b0, bus.ms_o_reg_wr},  32'd1);
        op_do(SW, 32'h1010, 32'hCAFEF00D, 5'd0);
        op_do(LW, 32'h10, 32'h0, 5'd3);  chk("alias", bus.ms_o_wb_data, 32'hCAFEF00D);

        // reset mid-traffic, while stalled
        op_do(LW, 32'h10, 32'h0, 5'd3);
        drive(LW, 32'h20, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        ms_rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) cycle();
        ms_rst = 1'b1;
        op_do(LW, 32'h10, 32'h0, 5'd3);  chk("post_reset_mem", bus.ms_o_wb_data, 32'hCAFEF00D);

        // randomized traffic over the prefilled words, with aliasing
        for (int n = 0; n < 2000; n++) begin
            idx = $urandom_range(0, PREFILL_W - 1);
            a   = (idx << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
            drive(op_tbl[$urandom_range(0, 9)], a, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 6) == 0,
                  $urandom_range(0, 19) == 0);
            cycle();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
